// File: rtl/rv32_mdu_seq_if.sv
// rtl/rv32_mdu_seq_if.sv - request/response and shared-ALU signal bundle for rv32_mdu_seq
//
// Signals:
//   start, op[1:0], a[31:0], b[31:0], kill  : request from the pipeline
//   ready, done, result[31:0]               : status and response to the pipeline
//   alu_da, alu_db[31:0], alu_ctr[3:0]      : operands and control driven to the shared ALU
//   alu_result[31:0]                        : combinational ALU result, same cycle
// Modports: slave (the MDU), master (pipeline plus ALU side).
interface rv32_mdu_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic [31:0] alu_da;
    logic [31:0] alu_db;
    logic [3:0]  alu_ctr;
    logic [31:0] alu_result;

    modport slave (
        input  start, op, a, b, kill, alu_result,
        output ready, done, result, alu_da, alu_db, alu_ctr
    );

    modport master (
        output start, op, a, b, kill, alu_result,
        input  ready, done, result, alu_da, alu_db, alu_ctr
    );
endinterface

// File: rtl/rv32_mdu_seq.sv
// rtl/rv32_mdu_seq.sv - sequential unsigned multiply/divide unit sharing one 32-bit ALU
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : rv32_mdu_seq_if.slave (start/op/a/b/kill in, ready/done/result out,
//          alu_da/alu_db/alu_ctr out to the shared ALU, alu_result back in)
// Parameters: ALU_ADD, ALU_SLTU (ALU control codes).
// Build option: MDU_DIV_EN enables the DIVU/REMU datapath; without it DIVU/REMU
// finish one cycle after acceptance with result 0.
// One bit iteration takes two cycles (PH_A, PH_B); 32 iterations, then FIN.
module rv32_mdu_seq #(
    parameter logic [3:0] ALU_ADD  = 4'b0000,
    parameter logic [3:0] ALU_SLTU = 4'b1010
) (
    input  logic           clk,
    input  logic           rst,
    rv32_mdu_seq_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, PH_A, PH_B, FIN} state_t;

    state_t      state, state_nx;
    logic [1:0]  op_q;
    logic [31:0] mcand;      // multiplicand or divisor
    logic [31:0] hi;         // product high word or partial remainder
    logic [31:0] lo;         // multiplier (shifts right) or dividend (static)
    logic [31:0] sum;
    logic [31:0] result_q;
    logic [31:0] fin_val;
    logic [4:0]  count;
    logic        accept;
    logic        skip;       // request that goes straight to FIN

`ifdef MDU_DIV_EN
    logic [31:0] quot;
    logic        ge_q;
    logic [32:0] rs;
    logic        ge;

    assign rs   = {hi, lo[5'd31 - count]};
    assign ge   = rs[32] | ~bus.alu_result[0];
    assign skip = bus.op[1] && (bus.b == 32'd0);
`else
    assign skip = bus.op[1];
`endif

    assign accept = (state == IDLE) && bus.start && !bus.kill;

    always_comb begin
        case (op_q)
            2'b00:   fin_val = lo;
            2'b01:   fin_val = hi;
`ifdef MDU_DIV_EN
            2'b10:   fin_val = quot;
            default: fin_val = hi;
`else
            default: fin_val = 32'd0;
`endif
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        bus.ready   = 1'b0;
        bus.done    = 1'b0;
        bus.result  = result_q;
        bus.alu_ctr = ALU_ADD;
        bus.alu_da  = 32'd0;
        bus.alu_db  = 32'd0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (accept) state_nx = skip ? FIN : PH_A;
            end
            PH_A: begin
                state_nx = bus.kill ? IDLE : PH_B;
`ifdef MDU_DIV_EN
                if (op_q[1]) begin
                    bus.alu_ctr = ALU_SLTU;
                    bus.alu_da  = rs[31:0];
                    bus.alu_db  = mcand;
                end else
`endif
                begin
                    bus.alu_da  = hi;
                    bus.alu_db  = lo[0] ? mcand : 32'd0;
                end
            end
            PH_B: begin
                if (bus.kill)          state_nx = IDLE;
                else if (count == 5'd31) state_nx = FIN;
                else                   state_nx = PH_A;
`ifdef MDU_DIV_EN
                if (op_q[1]) begin
                    bus.alu_da  = rs[31:0];
                    bus.alu_db  = ~mcand + 32'd1;
                end else
`endif
                begin
                    // sum < mcand after adding mcand means the add carried out
                    bus.alu_ctr = ALU_SLTU;
                    bus.alu_da  = sum;
                    bus.alu_db  = mcand;
                end
            end
            default: begin
                state_nx = IDLE;
                if (!bus.kill) begin
                    bus.done   = 1'b1;
                    bus.result = fin_val;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= 2'b00;
            mcand    <= 32'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            sum      <= 32'd0;
            count    <= 5'd0;
            result_q <= 32'd0;
`ifdef MDU_DIV_EN
            quot     <= 32'd0;
            ge_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q  <= bus.op;
                    count <= 5'd0;
                    mcand <= bus.op[1] ? bus.b : bus.a;
                    lo    <= bus.op[1] ? bus.a : bus.b;
                    hi    <= 32'd0;
`ifdef MDU_DIV_EN
                    // divide by zero: preload the architectural answers
                    quot  <= skip ? 32'hFFFF_FFFF : 32'd0;
                    if (skip) hi <= bus.a;
`endif
                end
                PH_A: if (!bus.kill) begin
`ifdef MDU_DIV_EN
                    if (op_q[1]) ge_q <= ge;
                    else
`endif
                    sum <= bus.alu_result;
                end
                PH_B: if (!bus.kill) begin
                    count <= count + 5'd1;
`ifdef MDU_DIV_EN
                    if (op_q[1]) begin
                        hi   <= ge_q ? bus.alu_result : rs[31:0];
                        quot <= {quot[30:0], ge_q};
                    end else
`endif
                    {hi, lo} <= {lo[0] & bus.alu_result[0], sum, lo[31:1]};
                end
                default: if (!bus.kill) result_q <= fin_val;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mdu_seq.sv
// tb/tb_rv32_mdu_seq.sv - scoreboard testbench for rv32_mdu_seq
module tb_rv32_mdu_seq;

    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_SLTU = 4'b1010;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32_mdu_seq_if bus();

    rv32_mdu_seq #(.ALU_ADD(C_ADD), .ALU_SLTU(C_SLTU)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // shared ALU
    assign bus.alu_result = (bus.alu_ctr == C_ADD)  ? bus.alu_da + bus.alu_db :
                            (bus.alu_ctr == C_SLTU) ? {31'd0, bus.alu_da < bus.alu_db} :
                            32'd0;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] exp_res[$];
    int          exp_cyc[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_res = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
`ifdef MDU_DIV_EN
            2'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
`else
            default: return 32'd0;
`endif
        endcase
    endfunction

    function automatic int latency(input logic [1:0] op, input logic [31:0] b);
        if (!op[1]) return 65;
`ifdef MDU_DIV_EN
        return (b == 0) ? 1 : 65;
`else
        if (b == 0) return 1;
        return 1;
`endif
    endfunction

    // monitor: pops the scoreboard whenever the DUT presents done
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.done === 1'b1) begin
                if (exp_res.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done at cycle %0d: got done=1 result=%h, expected no done", cyc, bus.result);
                end else begin
                    check("result", bus.result, exp_res.pop_front());
                    check("done_cycle", 32'(cyc), 32'(exp_cyc.pop_front()));
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (bus.ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("ready_timeout", 32'(bus.ready), 32'd1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        wait_ready();
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        last_res  = model(op, a, b);
        exp_res.push_back(last_res);
        exp_cyc.push_back(cyc + latency(op, b));
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        check("ready_busy", 32'(bus.ready), 32'd0);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_res.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            check("done_timeout", 32'(exp_res.size()), 32'd0);
            exp_res.delete();
            exp_cyc.delete();
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        drain();
        check("result_hold", bus.result, last_res);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        rst = 1'b1; bus.start = 1'b0; bus.kill = 1'b0;
        bus.op = 2'd0; bus.a = 32'd0; bus.b = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_ready",  32'(bus.ready), 32'd1);
        check("reset_done",   32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_alu_da", bus.alu_da, 32'd0);
        check("reset_alu_ctr", 32'(bus.alu_ctr), 32'(C_ADD));
        rst = 1'b0;
        @(negedge clk);

        run(2'd0, 32'd7, 32'd6);
        run(2'd1, 32'd7, 32'd6);
        run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(2'd2, 32'd100, 32'd7);
        run(2'd3, 32'd100, 32'd7);
        run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'd3, 32'hFFFF_FFFF, 32'h8000_0001);
        run(2'd2, 32'd5, 32'd0);
        run(2'd3, 32'd5, 32'd0);

        // back-to-back: start in the IDLE cycle right after FIN
        issue(2'd0, 32'd12345, 32'd678);
        issue(2'd1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        drain();

        // ignored start while busy, then kill: no done
        run(2'd0, 32'd11, 32'd13);
        wait_ready();
        t0 = cyc;
        bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd1000; bus.b = 32'd1000;
        @(negedge clk);
        bus.start = 1'b0;
        wait_until(t0 + 10);
        bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_until(t0 + 20);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill_ready", 32'(bus.ready), 32'd1);
        check("kill_result", bus.result, 32'd143);
        wait_until(t0 + 71);
        run(2'd0, 32'd3, 32'd3);

        // start and kill together in IDLE: dropped
        bus.start = 1'b1; bus.kill = 1'b1; bus.op = 2'd0; bus.a = 32'd2; bus.b = 32'd2;
        @(negedge clk);
        bus.start = 1'b0; bus.kill = 1'b0;
        check("startkill_ready", 32'(bus.ready), 32'd1);
        repeat (70) @(negedge clk);

        // kill in FIN suppresses done and keeps result
        t0 = cyc;
        bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd4; bus.b = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        wait_until(t0 + 65);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("finkill_ready", 32'(bus.ready), 32'd1);
        check("finkill_result", bus.result, 32'd9);
        repeat (3) @(negedge clk);

        // reset mid-operation
        t0 = cyc;
`ifdef MDU_DIV_EN
        bus.op = 2'd2;
`else
        bus.op = 2'd0;
`endif
        bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        wait_until(t0 + 30);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_result", bus.result, 32'd0);
        repeat (70) @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
            run(rop, ra, rb);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
